// File: rtl/vga_pkg.sv
// Shared timing defaults and payload types for the VGA image reader.
// Geometry defaults describe 640x480@60 with a centred 400x400 window.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_IMG_W    = 400;
    localparam int unsigned DEF_IMG_H    = 400;
    localparam int unsigned DEF_X_OFF    = 120;
    localparam int unsigned DEF_Y_OFF    = 40;

    localparam int unsigned ADDR_CNT_W = 18;
    localparam int unsigned ROM_ADDR_W = 32;
    localparam int unsigned RGB_W      = 24;

    // Full period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    localparam int unsigned DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int unsigned DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic in_win;
        logic first;
    } sideband_t;

    localparam rgb_t      DEF_BG_COLOR = rgb_t'(24'h000000);
    // Sideband value seen while idle: syncs deasserted (high), nothing active.
    localparam sideband_t SIDE_IDLE    = sideband_t'(5'b11000);

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable driven horizontal/vertical counters and the combinational
// sync, active, image-window and frame-origin flags derived from them.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned X_OFF    = DEF_X_OFF,
    parameter int unsigned Y_OFF    = DEF_Y_OFF
) (
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_pix_en,
    output sideband_t o_side_c
);

    localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HCNT_W  = $clog2(H_TOTAL);
    localparam int unsigned VCNT_W  = $clog2(V_TOTAL);

    logic [HCNT_W-1:0] r_hcnt;
    logic [VCNT_W-1:0] r_vcnt;
    logic              w_h_last;
    logic              w_v_last;
    logic              w_h_act;
    logic              w_v_act;
    logic              w_h_win;
    logic              w_v_win;

    assign w_h_last = (r_hcnt == HCNT_W'(H_TOTAL - 1));
    assign w_v_last = (r_vcnt == VCNT_W'(V_TOTAL - 1));

    // Raster position; the line wrap carries into the line counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_pix_en) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + VCNT_W'(1);
            end else begin
                r_hcnt <= r_hcnt + HCNT_W'(1);
            end
        end
    end

    // Flags for the position currently held in the counters.
    always_comb begin
        w_h_act = (r_hcnt < HCNT_W'(H_ACTIVE));
        w_v_act = (r_vcnt < VCNT_W'(V_ACTIVE));
        w_h_win = (r_hcnt >= HCNT_W'(X_OFF)) && (r_hcnt < HCNT_W'(X_OFF + IMG_W));
        w_v_win = (r_vcnt >= VCNT_W'(Y_OFF)) && (r_vcnt < VCNT_W'(Y_OFF + IMG_H));

        o_side_c        = SIDE_IDLE;
        o_side_c.hsync  = !((r_hcnt >= HCNT_W'(H_ACTIVE + H_FP)) &&
                            (r_hcnt <  HCNT_W'(H_ACTIVE + H_FP + H_SYNC)));
        o_side_c.vsync  = !((r_vcnt >= VCNT_W'(V_ACTIVE + V_FP)) &&
                            (r_vcnt <  VCNT_W'(V_ACTIVE + V_FP + V_SYNC)));
        o_side_c.active = w_h_act && w_v_act;
        o_side_c.in_win = w_h_act && w_v_act && w_h_win && w_v_win;
        o_side_c.first  = (r_hcnt == '0) && (r_vcnt == '0);
    end

endmodule

// File: rtl/vga_image_reader.sv
// Streams a windowed image from a 1-clock-latency ROM onto VGA outputs,
// keeping sync/blank sidebands aligned with the returned pixel data.
module vga_image_reader
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned X_OFF    = DEF_X_OFF,
    parameter int unsigned Y_OFF    = DEF_Y_OFF,
    parameter rgb_t        BG_COLOR = DEF_BG_COLOR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pix_en,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [RGB_W-1:0]      rom_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank_n,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  frame_start
);

    sideband_t             w_side;
    rgb_t                  w_pix;
    logic [ADDR_CNT_W-1:0] r_addr_cnt;
    logic [ROM_ADDR_W-1:0] r_rom_addr;
    sideband_t             r_side_a;
    sideband_t             r_side_b;
    logic                  r_va;
    logic                  r_vb;
    logic                  r_hsync;
    logic                  r_vsync;
    logic                  r_blank_n;
    rgb_t                  r_rgb;
    logic                  r_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .X_OFF    (X_OFF),
        .Y_OFF    (Y_OFF)
    ) u_timing (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_pix_en (pix_en),
        .o_side_c (w_side)
    );

    // Linear window address: counts window pixels in raster order, so no multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_cnt <= '0;
        end else if (w_side.first) begin
            r_addr_cnt <= '0;
        end else if (pix_en && w_side.in_win) begin
            r_addr_cnt <= r_addr_cnt + ADDR_CNT_W'(1);
        end
    end

    // Stage A: issue the address and capture the sidebands of the sampled pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_side_a   <= SIDE_IDLE;
            r_va       <= 1'b0;
        end else if (pix_en) begin
            r_rom_addr <= w_side.in_win ? ROM_ADDR_W'(r_addr_cnt) : '0;
            r_side_a   <= w_side;
            r_va       <= 1'b1;
        end else begin
            r_va       <= 1'b0;
        end
    end

    // Stage B: sidebands wait one clock while the ROM performs its read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_side_b <= SIDE_IDLE;
            r_vb     <= 1'b0;
        end else begin
            r_side_b <= r_side_a;
            r_vb     <= r_va;
        end
    end

    always_comb begin
        w_pix = '0;
        if (r_side_b.active) begin
            w_pix = r_side_b.in_win ? rgb_t'(rom_data) : BG_COLOR;
        end
    end

    // Stage C: merge ROM data with its sidebands; frame_start is a single-clock pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
        end else if (r_vb) begin
            r_hsync       <= r_side_b.hsync;
            r_vsync       <= r_side_b.vsync;
            r_blank_n     <= r_side_b.active;
            r_rgb         <= w_pix;
            r_frame_start <= r_side_b.first;
        end else begin
            r_frame_start <= 1'b0;
        end
    end

    assign rom_addr    = r_rom_addr;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank_n     = r_blank_n;
    assign r           = r_rgb.r;
    assign g           = r_rgb.g;
    assign b           = r_rgb.b;
    assign frame_start = r_frame_start;

endmodule
